// File: rtl/bus_round_robin_arbiter.sv
// bus_round_robin_arbiter: round-robin owner of the shared bus master port; optional watchdog via BUS_ARBITER_WATCHDOG_EN
module bus_round_robin_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  request,
  input  logic                busIn_begin_transaction,
  input  logic                busIn_end_transaction,
  input  logic                busIn_error,
  output logic [NUM_REQ-1:0]  grants,
  output logic [ID_WIDTH-1:0] owner_id,
  output logic                owner_valid,
  output logic                timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_BEGIN, ACTIVE} state_t;
  state_t                r_state;
  logic [NUM_REQ-1:0]    r_grants, r_owner_oh, w_pick_oh;
  logic [ID_WIDTH-1:0]   r_owner_id, r_ptr, w_pick, w_ptr_next;
  logic [2*NUM_REQ-1:0]  w_rot;
  logic                  r_owner_valid, w_found, w_owner_req, w_release, w_expire;
  assign w_rot       = {request, request} >> r_ptr;
  assign w_owner_req = |(request & r_owner_oh);
  assign w_ptr_next  = (r_owner_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_owner_id + ID_WIDTH'(1);
  assign w_release   = (r_state == WAIT_BEGIN && (busIn_end_transaction || busIn_error || !w_owner_req)) ||
                       (r_state == ACTIVE && (busIn_end_transaction || busIn_error));
  // first requester at or above the pointer, wrapping, found via the rotated request vector
  always_comb begin
    w_found   = 1'b0;
    w_pick    = '0;
    w_pick_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found   = 1'b1;
        w_pick    = ID_WIDTH'((int'(r_ptr) + i) % NUM_REQ);
        w_pick_oh = NUM_REQ'(1) << ((int'(r_ptr) + i) % NUM_REQ);
      end
    end
  end
`ifdef BUS_ARBITER_WATCHDOG_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_timeout;
  assign w_expire = (r_state == WAIT_BEGIN || r_state == ACTIVE) &&
                    (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !w_release;
  assign timeout  = r_timeout;
  // ownership age: cleared as WAIT_BEGIN is entered, counts while the bus is owned
  always_ff @(posedge clock) begin
    if (reset || r_state == GRANT) r_wd_cnt <= '0;
    else if (r_state == WAIT_BEGIN || r_state == ACTIVE) r_wd_cnt <= r_wd_cnt + CNT_W'(1);
    r_timeout <= !reset && w_expire;
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif
  // grant/ownership FSM with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grants      <= '0;
      r_owner_oh    <= '0;
      r_owner_id    <= '0;
      r_owner_valid <= 1'b0;
      r_ptr         <= '0;
    end else begin
      r_grants <= '0;
      case (r_state)
        IDLE: if (w_found) begin
          r_owner_id    <= w_pick;
          r_owner_oh    <= w_pick_oh;
          r_owner_valid <= 1'b1;
          r_grants      <= w_pick_oh;
          r_state       <= GRANT;
        end
        GRANT: begin
          r_ptr   <= w_ptr_next;
          r_state <= WAIT_BEGIN;
        end
        WAIT_BEGIN: if (w_release || w_expire) begin
          r_owner_valid <= 1'b0;
          r_state       <= IDLE;
        end else if (busIn_begin_transaction) r_state <= ACTIVE;
        default: if (w_release || w_expire) begin
          r_owner_valid <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end
  assign grants      = r_grants;
  assign owner_id    = r_owner_id;
  assign owner_valid = r_owner_valid;
endmodule
